// File: rtl/bp_be_issue_queue_pkg.sv
// Shared types, configuration lookups and width helpers for the BE issue queue.
package bp_be_issue_queue_pkg;

    // Processor configurations known to the issue queue.
    typedef enum logic [1:0] {
        e_bp_inv_cfg,
        e_bp_default_cfg
    } bp_params_e;

    // Enables the run-time sanity check on stray commits.
    localparam bit issue_queue_assert_en_lp = 1'b1;

    // Virtual address width supplied by a configuration.
    function automatic int vaddr_width(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return 39;
            default:          return 39;
        endcase
    endfunction

    // Branch metadata forwarded alongside each packet.
    function automatic int branch_metadata_fwd_width(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return 36;
            default:          return 36;
        endcase
    endfunction

    // Issue packet payload: pc, 32-bit instruction and branch metadata.
    function automatic int issue_pkt_width(int vaddr_w, int bmeta_w);
        return vaddr_w + 32 + bmeta_w;
    endfunction

    // Pointer width: index bits plus one wrap bit.
    function automatic int issue_queue_ptr_width(int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bp_be_issue_queue_ptr_ctrl.sv
// Write/read/commit pointer control: full/empty/count and ready/valid handshakes.
module bp_be_issue_queue_ptr_ctrl
    import bp_be_issue_queue_pkg::*;
#(
    parameter int issue_depth_p = 4,
    localparam int idx_width_lp = $clog2(issue_depth_p),
    localparam int ptr_width_lp = issue_queue_ptr_width(issue_depth_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    v_i,
    input  logic                    yumi_i,
    input  logic                    cmt_i,
    input  logic                    roll_i,
    input  logic                    clr_i,
    output logic                    ready_o,
    output logic                    v_o,
    output logic                    empty_o,
    output logic [ptr_width_lp-1:0] issued_cnt_o,
    output logic                    we_o,
    output logic [idx_width_lp-1:0] waddr_o,
    output logic [idx_width_lp-1:0] raddr_o
);

    typedef logic [ptr_width_lp-1:0] ptr_t;

    localparam ptr_t depth_lp = ptr_t'(issue_depth_p);

    ptr_t wptr_r, rptr_r, cptr_r;
    ptr_t wptr_n, rptr_n, cptr_n;
    logic full, cmt_ok;

    // Handshakes and status derived from the registered pointers.
    always_comb begin
        full         = ((wptr_r - cptr_r) == depth_lp);
        cmt_ok       = cmt_i & (rptr_r != cptr_r);
        ready_o      = ~full & ~clr_i & ~roll_i;
        v_o          = (rptr_r != wptr_r) & ~clr_i & ~roll_i;
        empty_o      = (wptr_r == cptr_r);
        issued_cnt_o = rptr_r - cptr_r;
        we_o         = v_i & ready_o;
        waddr_o      = wptr_r[idx_width_lp-1:0];
        raddr_o      = rptr_r[idx_width_lp-1:0];
    end

    // Next pointers: commit first, then roll/issue, then clear/enqueue.
    always_comb begin
        // NOTE: every output of this block is assigned on every path so no latch is inferred.
        cptr_n = cptr_r + ptr_t'(cmt_ok);
        rptr_n = rptr_r;
        wptr_n = wptr_r;
        if (roll_i)
            rptr_n = cptr_n;
        else if (yumi_i & v_o)
            rptr_n = rptr_r + ptr_t'(1);
        if (clr_i & roll_i)
            wptr_n = cptr_n;
        else if (clr_i)
            wptr_n = rptr_n;
        else if (we_o)
            wptr_n = wptr_r + ptr_t'(1);
    end

    // Pointer registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with <= so every register samples pre-edge values.
        if (!reset_n_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
            cptr_r <= '0;
        end else begin
            wptr_r <= wptr_n;
            rptr_r <= rptr_n;
            cptr_r <= cptr_n;
        end
    end

    // Flag a commit with nothing issued; the pointer logic already ignores it.
    always_ff @(posedge clk_i) begin
        if (issue_queue_assert_en_lp && reset_n_i)
            assert (!(cmt_i && (rptr_r == cptr_r)))
            else $warning("issue queue: commit with no issued entry ignored");
    end

endmodule

// File: rtl/bp_be_issue_queue.sv
// Multi-entry replay buffer between the FE queue handshake and BE dispatch.
module bp_be_issue_queue
    import bp_be_issue_queue_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_inv_cfg,
    parameter int issue_depth_p = 4,
    localparam int vaddr_width_lp = vaddr_width(bp_params_p),
    localparam int bmeta_width_lp = branch_metadata_fwd_width(bp_params_p),
    localparam int pkt_width_lp   = issue_pkt_width(vaddr_width_lp, bmeta_width_lp),
    localparam int ptr_width_lp   = issue_queue_ptr_width(issue_depth_p),
    localparam int idx_width_lp   = $clog2(issue_depth_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [pkt_width_lp-1:0] pkt_i,
    input  logic                    v_i,
    output logic                    ready_o,
    output logic [pkt_width_lp-1:0] pkt_o,
    output logic                    v_o,
    input  logic                    yumi_i,
    input  logic                    cmt_i,
    input  logic                    roll_i,
    input  logic                    clr_i,
    output logic                    empty_o,
    output logic [ptr_width_lp-1:0] issued_cnt_o
);

    logic                    we;
    logic [idx_width_lp-1:0] waddr, raddr;

    bp_be_issue_queue_ptr_ctrl #(
        .issue_depth_p(issue_depth_p)
    ) ptr_ctrl (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .v_i         (v_i),
        .yumi_i      (yumi_i),
        .cmt_i       (cmt_i),
        .roll_i      (roll_i),
        .clr_i       (clr_i),
        .ready_o     (ready_o),
        .v_o         (v_o),
        .empty_o     (empty_o),
        .issued_cnt_o(issued_cnt_o),
        .we_o        (we),
        .waddr_o     (waddr),
        .raddr_o     (raddr)
    );

    logic [pkt_width_lp-1:0] mem_r [issue_depth_p];

    // Packet storage: one write port at wptr, combinational read at rptr.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is not reset; v_o qualifies every read so stale contents are never consumed.
        if (we)
            mem_r[waddr] <= pkt_i;
    end

    assign pkt_o = mem_r[raddr];

endmodule

// File: tb/tb_bp_be_issue_queue.sv
// Self-checking bench: queue-based reference model plus directed and random stimulus.
module tb_bp_be_issue_queue;
    import bp_be_issue_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int PW    = issue_pkt_width(vaddr_width(e_bp_inv_cfg), branch_metadata_fwd_width(e_bp_inv_cfg));
    localparam int CW    = issue_queue_ptr_width(DEPTH);

    typedef logic [PW-1:0] pkt_t;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    pkt_t          pkt_i;
    logic          v_i, yumi_i, cmt_i, roll_i, clr_i;
    logic          ready_o, v_o, empty_o;
    pkt_t          pkt_o;
    logic [CW-1:0] issued_cnt_o;

    bp_be_issue_queue #(
        .bp_params_p  (e_bp_inv_cfg),
        .issue_depth_p(DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .pkt_i       (pkt_i),
        .v_i         (v_i),
        .ready_o     (ready_o),
        .pkt_o       (pkt_o),
        .v_o         (v_o),
        .yumi_i      (yumi_i),
        .cmt_i       (cmt_i),
        .roll_i      (roll_i),
        .clr_i       (clr_i),
        .empty_o     (empty_o),
        .issued_cnt_o(issued_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: live entries oldest first (commit point at index 0),
    // the first n_iss of which have been issued.
    pkt_t q[$];
    int   n_iss;

    int   n_checks = 0;
    int   n_pass   = 0;
    pkt_t pk[8];

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Compare every DUT output against the model for the inputs now applied.
    task automatic compare();
        bit exp_v, exp_ready;
        exp_v     = (q.size() > n_iss) && !clr_i && !roll_i;
        exp_ready = (q.size() < DEPTH) && !clr_i && !roll_i;
        check("v_o", 128'(v_o), 128'(exp_v));
        check("ready_o", 128'(ready_o), 128'(exp_ready));
        check("empty_o", 128'(empty_o), 128'(q.size() == 0));
        check("issued_cnt_o", 128'(issued_cnt_o), 128'(n_iss));
        if (exp_v) check("pkt_o", 128'(pkt_o), 128'(q[n_iss]));
    endtask

    // Apply inputs just after a rising edge, then compare at the falling edge.
    task automatic drive(bit v, pkt_t p, bit y, bit c, bit r, bit cl);
        v_i = v; pkt_i = p; yumi_i = y; cmt_i = c; roll_i = r; clr_i = cl;
        @(negedge clk_i);
        compare();
    endtask

    // Advance one clock and update the model with the inputs that were held.
    task automatic step();
        bit ev, er;
        @(posedge clk_i);
        ev = (q.size() > n_iss) && !clr_i && !roll_i;
        er = (q.size() < DEPTH) && !clr_i && !roll_i;
        if (!reset_n_i) begin
            q.delete();
            n_iss = 0;
        end else begin
            if (cmt_i && n_iss > 0) begin
                void'(q.pop_front());
                n_iss--;
            end
            if (roll_i) n_iss = 0;
            else if (yumi_i && ev) n_iss++;
            if (clr_i && roll_i) q.delete();
            else if (clr_i) while (q.size() > n_iss) void'(q.pop_back());
            else if (v_i && er) q.push_back(pkt_i);
        end
        #1;
    endtask

    task automatic idle();
        drive(0, '0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        idle(); step();
        reset_n_i = 1'b1;
    endtask

    task automatic fill(int n);
        for (int i = 0; i < n; i++) begin
            drive(1, pk[i], 0, 0, 0, 0); step();
        end
    endtask

    task automatic issue(int n);
        for (int i = 0; i < n; i++) begin
            drive(0, '0, 1, 0, 0, 0); step();
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++)
            pk[i] = pkt_t'({4{8'hA0 + 8'(i), 24'h5A5A00 + 24'(i)}});
        q.delete();
        n_iss = 0;
        reset_n_i = 1'b0;
        v_i = 0; pkt_i = '0; yumi_i = 0; cmt_i = 0; roll_i = 0; clr_i = 0;
        @(posedge clk_i); #1;

        // Reset state, then fill to full.
        do_reset();
        idle();
        check("rst_v", 128'(v_o), 128'(0));
        check("rst_ready", 128'(ready_o), 128'(1));
        check("rst_empty", 128'(empty_o), 128'(1));
        check("rst_cnt", 128'(issued_cnt_o), 128'(0));
        step();
        fill(4);
        idle();
        check("full_ready", 128'(ready_o), 128'(0));
        check("full_head", 128'(pkt_o), 128'(pk[0]));
        check("full_cnt", 128'(issued_cnt_o), 128'(0));
        step();

        // Issue A,B then roll: replay starts again at A.
        issue(2);
        drive(0, '0, 0, 0, 1, 0); step();
        idle();
        check("roll_head", 128'(pkt_o), 128'(pk[0]));
        check("roll_cnt", 128'(issued_cnt_o), 128'(0));
        step();
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, 1, 0, 0, 0);
            check("replay_order", 128'(pkt_o), 128'(pk[i]));
            step();
        end

        // Issue A,B, commit A, clear: C,D dropped, B stays issued.
        do_reset();
        fill(4);
        issue(2);
        drive(0, '0, 0, 1, 0, 0); step();
        drive(0, '0, 0, 0, 0, 1); step();
        idle();
        check("clr_v", 128'(v_o), 128'(0));
        check("clr_cnt", 128'(issued_cnt_o), 128'(1));
        step();
        drive(0, '0, 0, 1, 0, 0); step();
        idle();
        check("clr_cmt_empty", 128'(empty_o), 128'(1));
        step();

        // Full with commit and enqueue together: rejected, then accepted next cycle.
        do_reset();
        fill(4);
        issue(1);
        drive(1, pk[4], 0, 1, 0, 0);
        check("full_cmt_ready", 128'(ready_o), 128'(0));
        step();
        drive(1, pk[4], 0, 0, 0, 0);
        check("after_cmt_ready", 128'(ready_o), 128'(1));
        step();
        for (int i = 1; i < 5; i++) begin
            drive(0, '0, 1, 0, 0, 0);
            check("wrap_order", 128'(pkt_o), 128'(pk[i]));
            step();
        end

        // Clear, roll and commit together with two issued entries.
        do_reset();
        fill(4);
        issue(2);
        drive(0, '0, 0, 1, 1, 1); step();
        idle();
        check("crc_empty", 128'(empty_o), 128'(1));
        check("crc_ready", 128'(ready_o), 128'(1));
        check("crc_cnt", 128'(issued_cnt_o), 128'(0));
        step();

        // Reset mid-stream, then a stray commit.
        do_reset();
        fill(3);
        issue(1);
        do_reset();
        idle();
        check("mid_rst_v", 128'(v_o), 128'(0));
        check("mid_rst_empty", 128'(empty_o), 128'(1));
        check("mid_rst_cnt", 128'(issued_cnt_o), 128'(0));
        step();
        drive(0, '0, 0, 1, 0, 0); step();
        idle();
        check("stray_cmt_cnt", 128'(issued_cnt_o), 128'(0));
        check("stray_cmt_empty", 128'(empty_o), 128'(1));
        step();

        // Random traffic against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            pkt_t rp;
            bit   rv, ry, rc, rr, rcl;
            rp  = pkt_t'({$urandom, $urandom, $urandom, $urandom});
            rv  = ($urandom_range(0, 9) < 6);
            ry  = ($urandom_range(0, 9) < 5);
            rc  = ($urandom_range(0, 9) < 3) && (n_iss > 0);
            rr  = ($urandom_range(0, 99) < 5);
            rcl = ($urandom_range(0, 99) < 5);
            reset_n_i = ($urandom_range(0, 199) != 0);
            drive(rv, rp, ry, rc, rr, rcl);
            step();
        end
        reset_n_i = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bp_be_issue_queue.md
Name: bp_be_issue_queue

Overview:
- Parametrised multi-entry replay buffer between the FE queue handshake and the BE dispatch point. It generalises the single-entry issue register to issue_depth_p entries.
- Keeps three pointers:
  - write (enqueue)
  - read (speculative issue)
  - commit (retire)
- A cache-miss roll replays every issued-but-uncommitted packet in order. A clear discards un-issued packets. Commit frees slots.
- Sits between predecode and the register-file read/dispatch logic. It carries opaque issue packets.

Parameters:
- bp_params_p, e_bp_inv_cfg, processor configuration; supplies vaddr_width_p and branch_metadata_fwd_width_p.
- issue_depth_p, 4, number of entries. Must be a power of two, >= 2.
- localparam pkt_width_lp, `bp_be_issue_pkt_width(vaddr_width_p, branch_metadata_fwd_width_p), payload width.
- localparam ptr_width_lp, $clog2(issue_depth_p)+1, pointer width; the extra MSB is the wrap bit.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset; synchronous, active-low.
- pkt_i  in  pkt_width_lp  packet to enqueue.
- v_i  in  1  pkt_i valid.
- ready_o  out  1  space available; enqueue occurs when v_i & ready_o.
- pkt_o  out  pkt_width_lp  packet at the read pointer.
- v_o  out  1  pkt_o valid (un-issued entry exists).
- yumi_i  in  1  dispatch consumes pkt_o; advances the read pointer.
- cmt_i  in  1  retire the oldest issued entry; advances the commit pointer.
- roll_i  in  1  replay: read pointer returns to the commit pointer.
- clr_i  in  1  discard all un-issued entries.
- empty_o  out  1  no live entries (write == commit).
- issued_cnt_o  out  ptr_width_lp  issued-uncommitted count (read - commit).

Behaviour:
- Interface: one clock, clk_i. Reset is synchronous and active-low on reset_n_i.
- Pointers:
  - Names: wptr, rptr, cptr.
  - Width ptr_width_lp, modulo 2^ptr_width_lp. Low bits index storage.
  - Invariant: cptr <= rptr <= wptr in wrap-aware order.
- Reset (reset_n_i == 0 at posedge):
  - All pointers go to 0.
  - Next cycle: v_o=0, ready_o=1, empty_o=1, issued_cnt_o=0.
  - pkt_o is don't-care while v_o=0.
  - Reset mid-operation discards all entries, including issued ones.
- Full: (wptr - cptr) == issue_depth_p. Committed slots only are reusable.
- ready_o = ~full & ~clr_i & ~roll_i (combinational).
- v_o = (rptr != wptr) & ~clr_i & ~roll_i (combinational).
- pkt_o = mem[rptr] via combinational read. There is no enqueue-to-output bypass.
- Enqueue-to-v_o latency is 1 cycle.
- Per-cycle update order, using old values:
  1. cmt_i & (rptr != cptr): cptr' = cptr+1. Otherwise cptr' = cptr. Commit with nothing issued is ignored, and an assertion fires.
  2. roll_i: rptr' = cptr'. Otherwise, if yumi_i & v_o: rptr' = rptr+1. yumi_i without v_o is ignored.
  3. clr_i & roll_i: wptr' = cptr'. clr_i alone: wptr' = rptr' (un-issued entries dropped, issued ones kept). Neither, with v_i & ready_o: mem[wptr] = pkt_i and wptr' = wptr+1.
- Simultaneous events:
  - Enqueue and yumi on the same cycle at occupancy 0: enqueue happens, yumi is ignored (v_o=0).
  - Enqueue on the full cycle is rejected by ready_o=0.
  - Commit in the same cycle relieves full only on the next cycle; ready_o does not look ahead.
- Wrap-around: the pointer MSB toggles at issue_depth_p. Full/empty compare full pointers, never indices.
- empty_o = (wptr == cptr) and is registered-pointer derived.

Decomposition:
- bp_be_pkg additions:
  - issue-queue pointer typedef, parametrised via macro `bp_be_issue_queue_ptr_width.
  - assertion enable constant.
- Storage: bsg_mem_1r1w with width pkt_width_lp, els issue_depth_p, read_write_same_addr_p 0.
- One natural sub-module, bp_be_issue_queue_ptr_ctrl: the three-pointer update, full/empty/count and ready/valid logic.

Test Plan (issue_depth_p=4):
- Reset, then enqueue packets A,B,C,D on consecutive cycles with no yumi -> ready_o drops after D (full); v_o=1 with pkt_o=A; issued_cnt_o=0.
- Issue A,B via yumi_i, then pulse roll_i -> next cycle pkt_o=A, issued_cnt_o=0; re-issue yields A,B,C in order.
- Issue A,B, commit A, pulse clr_i -> wptr=rptr (C,D dropped), v_o=0, issued_cnt_o=1; cmt_i then gives empty_o=1.
- Full queue; cmt_i and v_i in the same cycle -> enqueue rejected that cycle; accepted the next cycle; wrap index 0 is reused and pkt_o order is preserved.
- clr_i & roll_i & cmt_i together with 2 issued entries -> cptr+1, rptr=wptr=cptr; empty_o=1; ready_o=1 the next cycle.
- Assert reset_n_i=0 mid-stream with 3 live entries -> next cycle v_o=0, empty_o=1, issued_cnt_o=0; a stray cmt_i is ignored and the assertion fires.
